// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer_pkg
// Description : Shared types and helpers for the ALU sequencer and its users.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_sequencer_pkg;

    // ALU operation encoding
    typedef enum logic [3:0] {
        ALU_OP_NOT  = 4'd0,
        ALU_OP_OR   = 4'd1,
        ALU_OP_AND  = 4'd2,
        ALU_OP_XOR  = 4'd3,
        ALU_OP_ADD  = 4'd4,
        ALU_OP_SUB  = 4'd5,
        ALU_OP_SHL  = 4'd6,
        ALU_OP_LSHR = 4'd7,
        ALU_OP_ASHR = 4'd8
    } alu_op_t;

    // ALU register-port control
    typedef enum logic [1:0] {
        REG_OP_NONE  = 2'd0,
        REG_OP_READ  = 2'd1,
        REG_OP_WRITE = 2'd2
    } reg_op_t;

    // Sequencer control states
    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_LOAD  = 2'd1,
        SEQ_WRITE = 2'd2,
        SEQ_RESP  = 2'd3
    } seq_state_t;

    // True for every encoding the ALU actually implements
    function automatic logic alu_op_is_legal(input alu_op_t op);
        logic legal;
        case (op)
            ALU_OP_NOT, ALU_OP_OR, ALU_OP_AND, ALU_OP_XOR,
            ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SHL, ALU_OP_LSHR,
            ALU_OP_ASHR: legal = 1'b1;
            default:     legal = 1'b0;
        endcase
        return legal;
    endfunction

    // True for the ops whose overflow output carries meaning (carry/borrow)
    function automatic logic alu_op_is_arith(input alu_op_t op);
        return (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first active
//               request at or after the pointer, wrapping modulo NREQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            valid_o
);

    int cand;

    // Scan from the pointer position and stop at the first active request
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!valid_o && req_i[cand[IDW-1:0]]) begin
                valid_o                 = 1'b1;
                grant_o[cand[IDW-1:0]]  = 1'b1;
                idx_o                   = cand[IDW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Shares one ALU between NREQ requesters. Round-robin grant,
//               fixed LOAD/WRITE drive sequence, valid/ready response and
//               persistent overflow/zero status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREQ  = 2,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  alu_op_t [NREQ-1:0]         req_mode,
    input  logic [NREQ-1:0][WIDTH-1:0] req_a,
    input  logic [NREQ-1:0][WIDTH-1:0] req_b,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [IDW-1:0]             resp_id,
    output logic [WIDTH-1:0]           resp_data,
    output logic                       resp_overflow,
    output logic                       resp_zero,
    output logic                       resp_error,
    output logic [WIDTH-1:0]           alu_a,
    output logic [WIDTH-1:0]           alu_b,
    output alu_op_t                    alu_mode,
    output reg_op_t                    alu_control,
    input  logic [WIDTH-1:0]           alu_out,
    input  logic                       alu_overflow,
    input  logic                       alu_zero,
    output logic                       flag_overflow,
    output logic                       flag_zero
);

    seq_state_t       state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   resp_id_q;
    logic [WIDTH-1:0] resp_data_q;
    logic             resp_overflow_q;
    logic             resp_zero_q;
    logic             resp_error_q;
    logic [WIDTH-1:0] alu_a_q, alu_b_q;
    alu_op_t          alu_mode_q;
    logic             flag_overflow_q, flag_zero_q;

    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_win_idx;
    logic             w_win_any;
    logic             w_handshake;
    alu_op_t          w_win_mode;
    logic             w_win_legal;
    logic             w_ovf_capture;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (w_grant),
        .idx_o   (w_win_idx),
        .valid_o (w_win_any)
    );

    // The winner's ready is the grant, so any valid winner in IDLE is a handshake
    assign w_handshake   = (state_q == SEQ_IDLE) && w_win_any;
    assign w_win_mode    = req_mode[w_win_idx];
    assign w_win_legal   = alu_op_is_legal(w_win_mode);
    // Logic/shift ops leave the ALU overflow line undefined; mask it off
    assign w_ovf_capture = alu_op_is_arith(alu_mode_q) & alu_overflow;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: illegal ops skip the ALU and answer immediately
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_IDLE:  if (w_handshake) state_d = w_win_legal ? SEQ_LOAD : SEQ_RESP;
            SEQ_LOAD:  state_d = SEQ_WRITE;
            SEQ_WRITE: state_d = SEQ_RESP;
            SEQ_RESP:  if (resp_ready) state_d = SEQ_IDLE;
            default:   state_d = SEQ_IDLE;
        endcase
    end

    // State-decoded outputs: grant only in IDLE, ALU control per phase
    always_comb begin
        req_ready   = '0;
        alu_control = REG_OP_NONE;
        resp_valid  = 1'b0;
        case (state_q)
            SEQ_IDLE:  req_ready   = w_grant;
            SEQ_LOAD:  alu_control = REG_OP_READ;
            SEQ_WRITE: alu_control = REG_OP_WRITE;
            SEQ_RESP:  resp_valid  = 1'b1;
            default:   req_ready   = '0;
        endcase
    end

    // Operand capture, result capture, rotation pointer and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q        <= '0;
            resp_id_q       <= '0;
            resp_data_q     <= '0;
            resp_overflow_q <= 1'b0;
            resp_zero_q     <= 1'b0;
            resp_error_q    <= 1'b0;
            alu_a_q         <= '0;
            alu_b_q         <= '0;
            alu_mode_q      <= ALU_OP_NOT;
            flag_overflow_q <= 1'b0;
            flag_zero_q     <= 1'b0;
        end else begin
            if (w_handshake) begin
                rr_ptr_q  <= (w_win_idx == IDW'(NREQ - 1)) ? '0 : w_win_idx + 1'b1;
                resp_id_q <= w_win_idx;
                if (w_win_legal) begin
                    // ALU operand lines only move for ops that will use the ALU
                    alu_a_q      <= req_a[w_win_idx];
                    alu_b_q      <= req_b[w_win_idx];
                    alu_mode_q   <= w_win_mode;
                    resp_error_q <= 1'b0;
                end else begin
                    resp_error_q    <= 1'b1;
                    resp_data_q     <= '0;
                    resp_overflow_q <= 1'b0;
                    resp_zero_q     <= 1'b0;
                end
            end
            if (state_q == SEQ_WRITE) begin
                resp_data_q     <= alu_out;
                resp_zero_q     <= alu_zero;
                resp_overflow_q <= w_ovf_capture;
                flag_zero_q     <= alu_zero;
                flag_overflow_q <= w_ovf_capture;
            end
        end
    end

    assign resp_id       = resp_id_q;
    assign resp_data     = resp_data_q;
    assign resp_overflow = resp_overflow_q;
    assign resp_zero     = resp_zero_q;
    assign resp_error    = resp_error_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_mode      = alu_mode_q;
    assign flag_overflow = flag_overflow_q;
    assign flag_zero     = flag_zero_q;

endmodule
`default_nettype wire
